// File: rtl/pbc_frame_ctrl.sv
// Frame sequencer for the 4-bit even-parity checker: accepts FRAME_LEN nibble+parity
// words over valid/ready, counts parity errors per frame. Optional macro: PBC_ABORT_EN.
module pbc_frame_ctrl #(
    parameter int FRAME_LEN = 8,
    parameter int ERR_W     = 4,
    localparam int WCW      = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       DIN,
    input  logic             PIN,
    output logic             PEC,
    output logic             pec_valid,
    output logic [ERR_W-1:0] err_cnt,
    output logic             busy,
    output logic             done,
    output logic             frame_err,
    output logic [1:0]       dbg_state
);

    // Handshake: a word transfers on a rising edge where in_valid && in_ready;
    // in_ready is decoded from state alone and never looks at in_valid.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WCW-1:0]   wcnt;
    logic             pec_next;
    logic             accept;
    logic             abort_hit;
    logic             last_word;
    logic             frame_end;
    logic [ERR_W-1:0] err_sum;

    assign pec_next = DIN[3] ^ DIN[2] ^ DIN[1] ^ DIN[0] ^ PIN;
    assign accept   = in_valid && (state == S_RUN);

`ifdef PBC_ABORT_EN
    assign abort_hit = pec_next;
`else
    assign abort_hit = 1'b0;
`endif

    assign last_word = (wcnt == WCW'(FRAME_LEN - 1));
    assign frame_end = accept && (last_word || abort_hit);

    // Saturating add: once all-ones, further errors are dropped.
    assign err_sum = (pec_next && (err_cnt != {ERR_W{1'b1}})) ? err_cnt + ERR_W'(1) : err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_RUN;
            S_RUN:  if (frame_end) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        dbg_state = state;
        case (state)
            S_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PEC       <= 1'b0;
            pec_valid <= 1'b0;
            err_cnt   <= '0;
            frame_err <= 1'b0;
            wcnt      <= '0;
        end else begin
            pec_valid <= accept;
            if (state == S_IDLE && start) begin
                err_cnt   <= '0;
                frame_err <= 1'b0;
                wcnt      <= '0;
            end
            if (accept) begin
                PEC     <= pec_next;
                err_cnt <= err_sum;
                wcnt    <= wcnt + WCW'(1);
            end
            // frame_err must include the final word, so use the post-add count.
            if (frame_end) begin
                frame_err <= (err_sum != '0);
            end
        end
    end

endmodule

// File: tb/tb_pbc_frame_ctrl.sv
// Randomized bench for pbc_frame_ctrl with a frame-level parity/error-count model.
module tb_pbc_frame_ctrl;

    localparam int FRAME_LEN = 8;
    localparam int ERR_W     = 2;
    localparam int ERR_MAX   = (1 << ERR_W) - 1;
`ifdef PBC_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       din = '0;
    logic             pin = 1'b0;
    logic             pec;
    logic             pec_valid;
    logic [ERR_W-1:0] err_cnt;
    logic             busy;
    logic             done;
    logic             frame_err;
    logic [1:0]       dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] word_q[$];   // directed words {pin, din}; random when empty
    logic       last_ferr = 1'b0;
    int         last_err  = 0;

    pbc_frame_ctrl #(.FRAME_LEN(FRAME_LEN), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .DIN(din), .PIN(pin), .PEC(pec), .pec_valid(pec_valid), .err_cnt(err_cnt),
        .busy(busy), .done(done), .frame_err(frame_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet_idle(input string tag);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pv"}, pec_valid, 0);
    endtask

    function automatic logic [4:0] rand_word(input int err_pct);
        logic [3:0] d;
        logic       p;
        d = 4'($urandom_range(0, 15));
        p = ^d;
        if (int'($urandom_range(1, 100)) <= err_pct) p = ~p;
        return {p, d};
    endfunction

    // Runs one frame from an IDLE negedge; returns at the following IDLE negedge.
    task automatic run_frame(input int bubble_pct, input int err_pct, input bit hold_start);
        int         acc = 0;
        int         errs = 0;
        int         iter = 0;
        bit         fin = 1'b0;
        logic [4:0] w;
        logic       exp_pec;
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = hold_start;
        check("run_ready", in_ready, 1);
        check("run_busy", busy, 1);
        check("start_clr_err", err_cnt, 0);
        check("start_clr_ferr", frame_err, 0);
        while (!fin) begin
            iter++;
            if (iter > 2000) begin
                check("frame_timeout", 1, 0);
                break;
            end
            in_valid = (int'($urandom_range(1, 100)) > bubble_pct);
            if (in_valid) begin
                w = (word_q.size() > 0) ? word_q.pop_front() : rand_word(err_pct);
            end else begin
                w = 5'($urandom_range(0, 31));
            end
            {pin, din} = w;
            exp_pec = ^w;
            @(negedge clk);
            if (in_valid) begin
                acc++;
                if (exp_pec) errs++;
                check("pec_valid", pec_valid, 1);
                check("pec", pec, exp_pec);
                check("err_cnt", err_cnt, (errs > ERR_MAX) ? ERR_MAX : errs);
                fin = (acc == FRAME_LEN) || (ABORT && exp_pec);
                check("done", done, fin);
                check("ready_after_word", in_ready, !fin);
                if (fin) check("frame_err", frame_err, errs != 0);
            end else begin
                check("bubble_pv", pec_valid, 0);
                check("bubble_done", done, 0);
                check("bubble_ready", in_ready, 1);
            end
        end
        in_valid = 1'b0;
        last_err  = (errs > ERR_MAX) ? ERR_MAX : errs;
        last_ferr = (errs != 0);
        @(negedge clk);
        check_quiet_idle("post_done");
        check("hold_err", err_cnt, last_err);
        check("hold_ferr", frame_err, last_ferr);
        start = 1'b0;
    endtask

    initial begin
        // Reset and idle behaviour
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_quiet_idle("reset");
        check("reset_pec", pec, 0);
        check("reset_err", err_cnt, 0);
        check("reset_ferr", frame_err, 0);
        in_valid = 1'b1;
        din = 4'b0001;
        pin = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_quiet_idle("idle_valid");
        end
        in_valid = 1'b0;

        // Clean frame, no bubbles
        repeat (FRAME_LEN) word_q.push_back({1'b1, 4'b1011});
        run_frame(0, 0, 1'b0);

        // Errors on words 2, 5 and 8
        for (int i = 1; i <= FRAME_LEN; i++)
            word_q.push_back((i == 2 || i == 5 || i == 8) ? {1'b0, 4'b0001} : {1'b1, 4'b1011});
        run_frame(0, 0, 1'b0);
        word_q.delete();

        // Bubbles and saturation
        run_frame(50, 0, 1'b0);
        run_frame(0, 100, 1'b0);
        run_frame(60, 100, 1'b0);

        // Reset mid-frame after three bad words
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            {pin, din} = rand_word(ABORT ? 0 : 100);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_quiet_idle("mid_rst");
        check("mid_rst_err", err_cnt, 0);
        check("mid_rst_ferr", frame_err, 0);
        @(negedge clk);
        check_quiet_idle("mid_rst_after");
        run_frame(30, 40, 1'b0);

        // Back-to-back frames with start held high throughout
        for (int f = 0; f < 4; f++) run_frame(20, 50, 1'b1);

        // Random frames
        for (int f = 0; f < 12; f++) begin
            run_frame(int'($urandom_range(0, 70)), int'($urandom_range(0, 60)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check_quiet_idle("gap");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
